// File: rtl/key_click_decoder.sv
// key_click_decoder
//   Groups single-cycle key press strobes into multi-click events. Presses
//   that arrive less than WINDOW_CYCLES edges after the previous accepted
//   press belong to the same group. When the window closes, the click count
//   (saturated at MAX_CLICKS) is offered on a valid/ready handshake.
//
//   Optional feature: define KEY_CLICK_OVF_EN to add clicks_ovf_o, a flag
//   reporting that the group had more presses than MAX_CLICKS.
//
// Ports
//   clk_i              single clock, rising edge
//   rst_ni             asynchronous active-low reset
//   key_pressed_stb_i  one-cycle press strobe from the debouncer
//   clicks_rdy_i       consumer accepts the report
//   clicks_ovf_o       group exceeded MAX_CLICKS (KEY_CLICK_OVF_EN only)
//   clicks_o           click count of the reported group, 0 when not valid
//   clicks_vld_o       clicks_o is valid
module key_click_decoder #(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int WINDOW_US    = 300_000,
  parameter int MAX_CLICKS   = 3
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              key_pressed_stb_i,
  input  logic                              clicks_rdy_i,
`ifdef KEY_CLICK_OVF_EN
  output logic                              clicks_ovf_o,
`endif
  output logic [$clog2(MAX_CLICKS+1)-1:0]   clicks_o,
  output logic                              clicks_vld_o
);

  localparam int WINDOW_CYCLES = CLK_FREQ_MHZ * WINDOW_US;
  localparam int CW            = $clog2(MAX_CLICKS + 1);
  // The timer never needs to hold more than WINDOW_CYCLES-1.
  localparam int TW            = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;

  localparam logic [CW-1:0] MAX_C  = CW'(MAX_CLICKS);
  localparam logic [TW-1:0] T_LAST = TW'(WINDOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GROUP, REPORT} state_t;

  state_t          state, state_d;
  logic [CW-1:0]   count, count_d;
  logic [TW-1:0]   timer, timer_d;
  logic            window_end;

`ifdef KEY_CLICK_OVF_EN
  logic            ovf, ovf_d;
`endif

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c < MAX_C) ? c + CW'(1) : MAX_C;
  endfunction

  // Timer holds (edges since last accepted press) - 1, so it reaches T_LAST
  // exactly at the edge last+WINDOW_CYCLES. A press on that edge is dropped.
  assign window_end = (timer == T_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      count <= '0;
      timer <= '0;
`ifdef KEY_CLICK_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_d;
      count <= count_d;
      timer <= timer_d;
`ifdef KEY_CLICK_OVF_EN
      ovf   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    count_d = count;
    timer_d = timer;
`ifdef KEY_CLICK_OVF_EN
    ovf_d   = ovf;
`endif
    case (state)
      IDLE: begin
        if (key_pressed_stb_i) begin
          state_d = GROUP;
          count_d = CW'(1);
          timer_d = '0;
`ifdef KEY_CLICK_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      GROUP: begin
        if (window_end) begin
          state_d = REPORT;
          timer_d = '0;
        end else if (key_pressed_stb_i) begin
          count_d = sat_inc(count);
          timer_d = '0;
`ifdef KEY_CLICK_OVF_EN
          if (count == MAX_C) ovf_d = 1'b1;
`endif
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      REPORT: begin
        // Presses are ignored here, including on the handshake edge.
        if (clicks_rdy_i) begin
          state_d = IDLE;
          count_d = '0;
`ifdef KEY_CLICK_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
        timer_d = '0;
      end
    endcase
  end

  // Outputs decode registered state only, never clicks_rdy_i.
  assign clicks_vld_o = (state == REPORT);
  assign clicks_o     = clicks_vld_o ? count : '0;
`ifdef KEY_CLICK_OVF_EN
  assign clicks_ovf_o = clicks_vld_o & ovf;
`endif

endmodule

// File: tb/tb_key_click_decoder.sv
// tb_key_click_decoder
//   Self-checking bench for key_click_decoder with WINDOW_CYCLES=100 and
//   MAX_CLICKS=3. A timestamp-based reference model tracks every edge; table
//   rows and hand-written sequences add fixed expectations.
module tb_key_click_decoder;

  localparam int W   = 100;
  localparam int MAX = 3;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       key_pressed_stb_i = 1'b0;
  logic       clicks_rdy_i = 1'b0;
  logic [1:0] clicks_o;
  logic       clicks_vld_o;
`ifdef KEY_CLICK_OVF_EN
  logic       clicks_ovf_o;
`endif

  key_click_decoder #(
    .CLK_FREQ_MHZ(100),
    .WINDOW_US   (1),
    .MAX_CLICKS  (MAX)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .key_pressed_stb_i(key_pressed_stb_i),
    .clicks_rdy_i     (clicks_rdy_i),
`ifdef KEY_CLICK_OVF_EN
    .clicks_ovf_o     (clicks_ovf_o),
`endif
    .clicks_o         (clicks_o),
    .clicks_vld_o     (clicks_vld_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  // Reference model: group described by timestamp of last accepted press.
  int m_phase = 0;   // 0 waiting for press, 1 collecting, 2 reporting
  int m_last  = 0;
  int m_cnt   = 0;
  int m_ovf   = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic int dut_ovf();
`ifdef KEY_CLICK_OVF_EN
    return int'(clicks_ovf_o);
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_ovf = 0; m_last = 0;
  endtask

  task automatic model_edge(input bit stb, input bit rdy);
    if (m_phase == 0) begin
      if (stb) begin m_phase = 1; m_cnt = 1; m_ovf = 0; m_last = edge_n; end
    end else if (m_phase == 1) begin
      if (edge_n - m_last >= W) m_phase = 2;
      else if (stb) begin
        if (m_cnt >= MAX) m_ovf = 1;
        else m_cnt = m_cnt + 1;
        m_last = edge_n;
      end
    end else begin
      if (rdy) begin m_phase = 0; m_cnt = 0; m_ovf = 0; end
    end
  endtask

  task automatic step(input bit stb, input bit rdy);
    key_pressed_stb_i = stb;
    clicks_rdy_i      = rdy;
    @(posedge clk_i);
    edge_n++;
    model_edge(stb, rdy);
    #1;
    chk("model_vld", int'(clicks_vld_o), (m_phase == 2) ? 1 : 0);
    chk("model_clicks", int'(clicks_o), (m_phase == 2) ? m_cnt : 0);
`ifdef KEY_CLICK_OVF_EN
    chk("model_ovf", int'(clicks_ovf_o), (m_phase == 2) ? m_ovf : 0);
`endif
  endtask

  task automatic idle_steps(input int n, input bit rdy, output int highs);
    highs = 0;
    for (int i = 0; i < n; i++) begin
      step(1'b0, rdy);
      if (clicks_vld_o) highs++;
    end
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset(input string name);
    #2;
    rst_ni = 1'b0;
    #1;
    chk({name, "_vld"}, int'(clicks_vld_o), 0);
    chk({name, "_clicks"}, int'(clicks_o), 0);
    chk({name, "_ovf"}, dut_ovf(), 0);
    model_reset();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  // Single press with rdy high: report of 1 exactly 100 edges later.
  task automatic single_click_check(input string name);
    int highs;
    step(1'b1, 1'b1);
    idle_steps(99, 1'b1, highs);
    chk({name, "_early"}, highs, 0);
    step(1'b0, 1'b1);
    chk({name, "_vld"}, int'(clicks_vld_o), 1);
    chk({name, "_clicks"}, int'(clicks_o), 1);
    chk({name, "_ovf"}, dut_ovf(), 0);
    step(1'b0, 1'b1);
    chk({name, "_pulse"}, int'(clicks_vld_o), 0);
  endtask

  typedef struct {
    int n;
    int spacing;
    int exp_clicks;
    int rep_edge;   // edge of report, relative to first press
    int exp_ovf;
  } row_t;

  row_t rows[6];
  int   per_mille[6];

  initial begin
    int highs;
    bit stb;

    rows[0] = '{n: 1, spacing: 1,  exp_clicks: 1, rep_edge: 100, exp_ovf: 0};
    rows[1] = '{n: 2, spacing: 99, exp_clicks: 2, rep_edge: 199, exp_ovf: 0};
    rows[2] = '{n: 5, spacing: 10, exp_clicks: 3, rep_edge: 140, exp_ovf: 1};
    rows[3] = '{n: 3, spacing: 50, exp_clicks: 3, rep_edge: 200, exp_ovf: 0};
    rows[4] = '{n: 4, spacing: 1,  exp_clicks: 3, rep_edge: 103, exp_ovf: 1};
    rows[5] = '{n: 2, spacing: 60, exp_clicks: 2, rep_edge: 160, exp_ovf: 0};
    per_mille = '{5, 10, 30, 100, 3, 20};

    // Reset state
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_vld", int'(clicks_vld_o), 0);
    chk("reset_clicks", int'(clicks_o), 0);
    chk("reset_ovf", dut_ovf(), 0);
    rst_ni = 1'b1;
    model_reset();
    idle_steps(5, 1'b1, highs);
    chk("idle_quiet", highs, 0);

    // Table-driven groups, rdy held high so every report is a one-cycle pulse.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k <= rows[r].rep_edge + 3; k++) begin
        stb = ((k % rows[r].spacing) == 0) && ((k / rows[r].spacing) < rows[r].n);
        step(stb, 1'b1);
        chk($sformatf("row%0d_vld", r), int'(clicks_vld_o),
            (k == rows[r].rep_edge) ? 1 : 0);
        chk($sformatf("row%0d_clicks", r), int'(clicks_o),
            (k == rows[r].rep_edge) ? rows[r].exp_clicks : 0);
`ifdef KEY_CLICK_OVF_EN
        chk($sformatf("row%0d_ovf", r), int'(clicks_ovf_o),
            (k == rows[r].rep_edge) ? rows[r].exp_ovf : 0);
`endif
      end
    end

    // Press on the window-closing edge is dropped, no second report.
    step(1'b1, 1'b1);
    idle_steps(99, 1'b1, highs);
    step(1'b1, 1'b1);
    chk("edge_drop_vld", int'(clicks_vld_o), 1);
    chk("edge_drop_clicks", int'(clicks_o), 1);
    idle_steps(250, 1'b1, highs);
    chk("edge_drop_no_second", highs, 0);

    // Back-pressure: report held while rdy low, presses ignored.
    step(1'b1, 1'b0);
    idle_steps(100, 1'b0, highs);
    chk("hold_vld", int'(clicks_vld_o), 1);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0);
      chk("hold_stable_vld", int'(clicks_vld_o), 1);
      chk("hold_stable_clicks", int'(clicks_o), 1);
    end
    step(1'b1, 1'b1);
    chk("handshake_vld", int'(clicks_vld_o), 0);
    chk("handshake_clicks", int'(clicks_o), 0);
    single_click_check("after_hs");

    // Reset during REPORT
    step(1'b1, 1'b0);
    idle_steps(100, 1'b0, highs);
    chk("pre_rst_vld", int'(clicks_vld_o), 1);
    async_reset("rst_report");
    idle_steps(150, 1'b1, highs);
    chk("rst_report_stale", highs, 0);
    single_click_check("rst_report_next");

    // Reset during GROUP after overflow
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    idle_steps(30, 1'b1, highs);
    async_reset("rst_group");
    idle_steps(200, 1'b1, highs);
    chk("rst_group_stale", highs, 0);
    single_click_check("rst_group_next");

    // Randomized traffic checked against the model every edge.
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 700; i++) begin
        step($urandom_range(0, 999) < per_mille[b],
             $urandom_range(0, 3) != 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
